oci_trace_capture: RTL
======================

Name: oci_trace_capture

Overview:
- Parametrised successor to the debug-trace test-bench hook in the Nios II OCI.
- Accepts packed debug-capture-trace (DCT) buffers of NUM_SLOTS slots, each with a valid-slot count.
- Unpacks them one slot per cycle into a first-word-fall-through FIFO for a downstream consumer.
- Tracks overflow, count errors and slot totals, and sequences end-of-test flush into a sticky test_has_ended indication.

Parameters:
- SLOT_W, 10, width of one trace slot in bits
- NUM_SLOTS, 3, slots per dct_buffer word
- CNT_W, 4, width of dct_count
- DEPTH, 16, FIFO depth in slots; must be a power of 2, at least 2

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- dct_buffer  in  SLOT_W*NUM_SLOTS  packed slots; slot i = bits [i*SLOT_W +: SLOT_W]
- dct_count  in  CNT_W  number of valid slots in dct_buffer, starting at slot 0
- dct_valid  in  1  buffer/count valid
- dct_ready  out  1  block accepts buffer this cycle
- test_ending  in  1  level; request end-of-test flush
- out_data  out  SLOT_W  FIFO head slot
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops head
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- slot_total  out  32  slots successfully written to FIFO, saturating
- overflow  out  1  sticky; at least one slot dropped on full FIFO
- count_err  out  1  sticky; dct_count > NUM_SLOTS seen
- test_has_ended  out  1  sticky; flush complete

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset (synchronous, any state, including mid-unpack):
  - state=IDLE; FIFO emptied; fill_level=0; out_valid=0; out_data=0.
  - slot_total=0; overflow=0; count_err=0; test_has_ended=0; ending latch=0.
- States:
  - IDLE: dct_ready = !ending_latched && !test_ending.
    - Accept on dct_valid && dct_ready: latch dct_buffer, set remaining = min(dct_count, NUM_SLOTS), slot index=0.
    - If dct_count > NUM_SLOTS, set count_err and clamp.
    - If the clamped count is 0, the accept is a no-op and the block stays IDLE. Otherwise go to UNPACK.
  - UNPACK: dct_ready=0. Each cycle push slot[index] to the FIFO, index++, remaining--. After the last slot, go to IDLE, or to DRAIN if the ending latch is set.
    - Latency: slot 0 is visible on out_data/out_valid the cycle after entering UNPACK, i.e. 2 cycles after the accept edge.
  - DRAIN: dct_ready=0. Wait for the FIFO to empty via consumer pops, then go to DONE.
  - DONE: test_has_ended=1, dct_ready=0. Holds until reset.
- test_ending:
  - Sets ending_latch on any cycle; the latch is sticky.
  - Has priority over dct_valid in the same cycle: that buffer is not accepted.
  - Asserted in IDLE: go to DRAIN next cycle.
  - Asserted during UNPACK: the current buffer completes fully, then go to DRAIN.
- FIFO:
  - Push allowed when not full, or when full with a pop in the same cycle. Simultaneous push and pop leaves fill_level unchanged.
  - Push while full without a pop: slot dropped, overflow set, unpack continues (never stalls), slot_total not incremented.
  - Pop on out_valid && out_ready. Pop while empty is ignored.
  - Pointers wrap modulo DEPTH. fill_level ranges 0..DEPTH.
- slot_total increments by 1 per accepted push and saturates at 32'hFFFFFFFF.
- All outputs are registered except dct_ready, which is decoded from registered state plus test_ending.

Test Plan:
- Single buffer: dct_buffer={10'h3,10'h2,10'h1}, count=3, out_ready=1 -> out_data 1,2,3 on consecutive cycles starting 2 cycles after accept; slot_total=3; dct_ready low for 3 cycles.
- Count edge cases: count=0 -> no FIFO write, count_err=0; count=5 -> 3 slots written, count_err=1 sticky.
- Overflow: out_ready=0, six buffers of count=3 (18 slots, DEPTH=16) -> fill_level=16, overflow=1, slot_total=16; FIFO holds the first 16 slots in order.
- Full with simultaneous pop: FIFO full, out_ready=1 during UNPACK -> no drops, overflow stays 0, fill_level stays 16.
- End of test: test_ending pulsed mid-UNPACK with 5 slots queued -> buffer completes, no further accept, test_has_ended rises the cycle after the last pop and remains high.
- Reset mid-UNPACK with fill_level=7 -> next cycle all outputs at reset values, dct_ready=1.

Source files
------------

// File: rtl/oci_trace_capture.sv
// Debug-trace capture: unpacks multi-slot DCT buffers one slot per cycle into a FWFT FIFO,
// with overflow/count-error/total tracking and an end-of-test flush sequence.
module oci_trace_capture #(
    parameter int unsigned SLOT_W    = 10,
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SLOT_W*NUM_SLOTS-1:0] dct_buffer,
    input  logic [CNT_W-1:0]            dct_count,
    input  logic                        dct_valid,
    output logic                        dct_ready,
    input  logic                        test_ending,
    output logic [SLOT_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      fill_level,
    output logic [31:0]                 slot_total,
    output logic                        overflow,
    output logic                        count_err,
    output logic                        test_has_ended
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned IDX_W  = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0] NUM_SLOTS_C = CNT_W'(NUM_SLOTS);

    typedef enum logic [1:0] {StIdle, StUnpack, StDrain, StDone} state_e;

    state_e                      state_q, state_d;
    logic [SLOT_W*NUM_SLOTS-1:0] buf_q;
    logic [CNT_W-1:0]            remaining_q;
    logic [IDX_W-1:0]            idx_q;
    logic                        ending_q;
    logic [SLOT_W-1:0]           mem_q [DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic [SLOT_W-1:0]           out_data_q, head_d, push_data;
    logic [31:0]                 total_q;
    logic                        overflow_q, count_err_q, ended_q;

    logic             accept, count_over, pop, push_req, push_ok, drop, full, last_slot;
    logic [CNT_W-1:0] count_clamped;

    always_comb begin
        count_over    = dct_count > NUM_SLOTS_C;
        count_clamped = count_over ? NUM_SLOTS_C : dct_count;
        accept        = dct_valid && dct_ready;
        full          = fill_q == FILL_W'(DEPTH);
        pop           = (fill_q != '0) && out_ready;
        push_req      = state_q == StUnpack;
        push_ok       = push_req && (!full || pop);
        drop          = push_req && full && !pop;
        last_slot     = remaining_q == CNT_W'(1);
        push_data     = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (idx_q == IDX_W'(i)) push_data = buf_q[i*SLOT_W +: SLOT_W];
        end
    end

    // Next FIFO head is computed ahead so out_data can be a plain register.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok && !pop) fill_d = fill_q + FILL_W'(1);
        else if (!push_ok && pop) fill_d = fill_q - FILL_W'(1);
        if (fill_d == '0) head_d = '0;
        else if (push_ok && wr_ptr_q == rd_ptr_d) head_d = push_data;
        else head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (test_ending || ending_q) state_d = StDrain;
                else if (accept && count_clamped != '0) state_d = StUnpack;
            end
            StUnpack: begin
                if (last_slot) state_d = (ending_q || test_ending) ? StDrain : StIdle;
            end
            StDrain: begin
                if (fill_d == '0) state_d = StDone;
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dct_ready = (state_q == StIdle) && !ending_q && !test_ending;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q       <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            ending_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            total_q     <= '0;
            overflow_q  <= 1'b0;
            count_err_q <= 1'b0;
            ended_q     <= 1'b0;
        end else begin
            if (accept) begin
                buf_q       <= dct_buffer;
                remaining_q <= count_clamped;
                idx_q       <= '0;
            end else if (state_q == StUnpack) begin
                remaining_q <= remaining_q - CNT_W'(1);
                idx_q       <= idx_q + IDX_W'(1);
            end
            if (test_ending) ending_q <= 1'b1;
            if (accept && count_over) count_err_q <= 1'b1;
            if (drop) overflow_q <= 1'b1;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (total_q != 32'hFFFF_FFFF) total_q <= total_q + 32'd1;
            end
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            out_data_q <= head_d;
            if (state_d == StDone) ended_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign out_data       = out_data_q;
    assign out_valid      = fill_q != '0;
    assign fill_level     = fill_q;
    assign slot_total     = total_q;
    assign overflow       = overflow_q;
    assign count_err      = count_err_q;
    assign test_has_ended = ended_q;

endmodule
